// File: rtl/display_conversion_scheduler.sv
// Shares one sequential binary-to-BCD converter across NUM_CH instrument displays, one sweep per tick.
// Optional macro SNAPSHOT_EN: every channel of a sweep converts a snapshot of chan_value taken at sweep start.
module display_conversion_scheduler #(
  parameter int NUM_CH         = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic [NUM_CH-1:0]    chan_en,
  input  logic [NUM_CH*16-1:0] chan_value,
  output logic                 conv_start,
  output logic [15:0]          conv_binary,
  input  logic                 conv_done,
  input  logic [15:0]          conv_digits,
  output logic [NUM_CH*16-1:0] digits_out,
  output logic [NUM_CH-1:0]    digits_valid,
  output logic [NUM_CH-1:0]    chan_err,
  output logic                 sweep_busy,
  output logic                 sweep_done
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [CH_W-1:0]  ch, sel_idx;
  logic             sel_fire, sweep_begin, conv_end, conv_timeout, pending;
  logic [TMR_W-1:0] timer;
  logic [15:0]      value_arr  [NUM_CH];
  logic [15:0]      digits_reg [NUM_CH];
  logic [15:0]      sel_value;
  logic [CH_W:0]    first_sel, after_sel;

  // Lowest enabled channel with index >= from; MSB of the result flags that one exists.
  function automatic logic [CH_W:0] next_channel(input logic [NUM_CH-1:0] en, input int from);
    logic [CH_W:0] r;
    r = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (en[i] && (i >= from)) r = {1'b1, CH_W'(i)};
    end
    return r;
  endfunction

  generate
    for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
      assign value_arr[g]            = chan_value[g*16 +: 16];
      assign digits_out[g*16 +: 16]  = digits_reg[g];
    end
  endgenerate

  assign first_sel = next_channel(chan_en, 0);
  assign after_sel = next_channel(chan_en, int'(ch) + 1);

  always_comb begin
    state_nxt    = state;
    sel_fire     = 1'b0;
    sel_idx      = ch;
    conv_end     = 1'b0;
    conv_timeout = 1'b0;
    case (state)
      S_IDLE: begin
        if ((tick || pending) && (|chan_en)) begin
          state_nxt = S_START;
          sel_fire  = 1'b1;
          sel_idx   = first_sel[CH_W-1:0];
        end
      end
      S_START: state_nxt = S_WAIT;
      S_WAIT: begin
        conv_end     = conv_done;
        conv_timeout = !conv_done && (timer == TMR_W'(TIMEOUT_CYCLES - 1));
        if (conv_end || conv_timeout) begin
          if (after_sel[CH_W]) begin
            state_nxt = S_START;
            sel_fire  = 1'b1;
            sel_idx   = after_sel[CH_W-1:0];
          end else begin
            state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        // A queued request chains straight into the next sweep so its START follows DONE directly.
        state_nxt = S_IDLE;
        if ((tick || pending) && (|chan_en)) begin
          state_nxt = S_START;
          sel_fire  = 1'b1;
          sel_idx   = first_sel[CH_W-1:0];
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign sweep_begin = sel_fire && ((state == S_IDLE) || (state == S_DONE));

`ifdef SNAPSHOT_EN
  logic [15:0] snap_arr [NUM_CH];

  always_ff @(posedge clk) begin
    if (sweep_begin) begin
      for (int i = 0; i < NUM_CH; i++) snap_arr[i] <= value_arr[i];
    end
  end

  // The first channel reads live inputs since the snapshot is written on that same edge.
  assign sel_value = sweep_begin ? value_arr[sel_idx] : snap_arr[sel_idx];
`else
  assign sel_value = value_arr[sel_idx];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      ch           <= '0;
      pending      <= 1'b0;
      timer        <= '0;
      conv_start   <= 1'b0;
      conv_binary  <= '0;
      digits_valid <= '0;
      chan_err     <= '0;
      sweep_busy   <= 1'b0;
      sweep_done   <= 1'b0;
    end else begin
      state      <= state_nxt;
      conv_start <= sel_fire;
      sweep_done <= (state_nxt == S_DONE);
      sweep_busy <= (state_nxt != S_IDLE);

      if (sel_fire) begin
        ch          <= sel_idx;
        conv_binary <= sel_value;
      end

      if (state == S_WAIT) timer <= timer + 1'b1;
      else                 timer <= '0;

      // One-deep request queue: extra ticks during a sweep coalesce.
      if (sweep_begin)                     pending <= 1'b0;
      else if (tick && (state != S_IDLE))  pending <= 1'b1;
      else if (state == S_IDLE)            pending <= 1'b0;

      if (conv_end) begin
        digits_valid[ch] <= 1'b1;
        chan_err[ch]     <= 1'b0;
      end else if (conv_timeout) begin
        chan_err[ch]     <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) digits_reg[i] <= '0;
    end else if (conv_end) begin
      digits_reg[ch] <= conv_digits;
    end
  end

endmodule
